// File: rtl/mc_pkg.sv
// ============================================================================
//  Module   : mc_pkg
//  Brief    : Shared encodings for the multi-cycle MIPS-subset controller.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_pkg;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD   = 6'b100000;
    localparam logic [5:0] FN_ADDU  = 6'b100001;
    localparam logic [5:0] FN_SUB   = 6'b100010;
    localparam logic [5:0] FN_SUBU  = 6'b100011;
    localparam logic [5:0] FN_OR    = 6'b100101;
    localparam logic [5:0] FN_SLT   = 6'b101010;
    localparam logic [5:0] FN_SLTU  = 6'b101011;

    localparam logic [2:0] ALU_ADDU = 3'b000;
    localparam logic [2:0] ALU_ADD  = 3'b001;
    localparam logic [2:0] ALU_OR   = 3'b010;
    localparam logic [2:0] ALU_SUBU = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    localparam logic [3:0] S_IF     = 4'd0;
    localparam logic [3:0] S_ID     = 4'd1;
    localparam logic [3:0] S_EXE_R  = 4'd2;
    localparam logic [3:0] S_EXE_I  = 4'd3;
    localparam logic [3:0] S_EXE_MA = 4'd4;
    localparam logic [3:0] S_MEM_RD = 4'd5;
    localparam logic [3:0] S_MEM_WR = 4'd6;
    localparam logic [3:0] S_WB_R   = 4'd7;
    localparam logic [3:0] S_WB_I   = 4'd8;
    localparam logic [3:0] S_WB_LD  = 4'd9;
    localparam logic [3:0] S_BR     = 4'd10;
    localparam logic [3:0] S_JMP    = 4'd11;

    localparam logic [1:0] NPC_SEQ  = 2'b00;
    localparam logic [1:0] NPC_BR   = 2'b01;
    localparam logic [1:0] NPC_JMP  = 2'b10;

endpackage

`default_nettype wire

// File: rtl/mc_alu_dec.sv
// ============================================================================
//  Module   : mc_alu_dec
//  Brief    : R-type func field to ALUctr decode with legality flag.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] func_i,
    output logic [2:0] alu_ctr_o,
    output logic       legal_o
);

    always_comb begin
        alu_ctr_o = ALU_ADDU;
        legal_o   = 1'b1;
        case (func_i)
            FN_ADD:  alu_ctr_o = ALU_ADD;
            FN_ADDU: alu_ctr_o = ALU_ADDU;
            FN_SUB:  alu_ctr_o = ALU_SUB;
            FN_SUBU: alu_ctr_o = ALU_SUBU;
            FN_OR:   alu_ctr_o = ALU_OR;
            FN_SLT:  alu_ctr_o = ALU_SLT;
            FN_SLTU: alu_ctr_o = ALU_SLTU;
            default: legal_o   = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/multicycle_ctrl.sv
// ============================================================================
//  Module   : multicycle_ctrl
//  Brief    : Multi-cycle IF/ID/EXE/MEM/WB sequencer driving datapath controls.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module multicycle_ctrl
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] func,
    input  logic       zero,
    input  logic       overflow,
    output logic       PCWr,
    output logic       IRWr,
    output logic       RegWr,
    output logic       MemWr,
    output logic [2:0] ALUctr,
    output logic       ALUSrc,
    output logic       ExtOp,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic [1:0] nPCsel,
    output logic       instr_done,
    output logic       ill_op,
    output logic       ovf_exc
);

    logic [3:0] state_q, state_d;
    logic       ov_flag_q, ov_flag_d;
    logic [2:0] w_fn_ctr;
    logic       w_fn_legal;
    logic       w_id_ill;

    mc_alu_dec u_alu_dec (
        .func_i    (func),
        .alu_ctr_o (w_fn_ctr),
        .legal_o   (w_fn_legal)
    );

    always_comb begin
        case (op)
            OP_R:                        w_id_ill = ~w_fn_legal;
            OP_ADDIU, OP_ORI, OP_LW,
            OP_SW, OP_BEQ, OP_J:         w_id_ill = 1'b0;
            default:                     w_id_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = S_ID;
            S_ID: begin
                if (!w_id_ill) begin
                    case (op)
                        OP_R:              state_d = S_EXE_R;
                        OP_ADDIU, OP_ORI:  state_d = S_EXE_I;
                        OP_LW, OP_SW:      state_d = S_EXE_MA;
                        OP_BEQ:            state_d = S_BR;
                        OP_J:              state_d = S_JMP;
                        default:           state_d = S_IF;
                    endcase
                end
            end
            S_EXE_R:  state_d = S_WB_R;
            S_EXE_I:  state_d = S_WB_I;
            S_EXE_MA: state_d = (op == OP_LW) ? S_MEM_RD : S_MEM_WR;
            S_MEM_RD: state_d = S_WB_LD;
            default:  state_d = S_IF;
        endcase
    end

    // Only signed add/sub (ALUctr[1:0]=01) can trap; the flag lives until next fetch.
    always_comb begin
        ov_flag_d = ov_flag_q;
        if (state_q == S_IF) begin
            ov_flag_d = 1'b0;
        end else if (state_q == S_EXE_R && overflow && w_fn_ctr[1:0] == 2'b01) begin
            ov_flag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IF;
            ov_flag_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ov_flag_q <= ov_flag_d;
        end
    end

    // Outputs are gated by rst_n so that even S_IF strobes stay low during reset.
    always_comb begin
        PCWr       = 1'b0;
        IRWr       = 1'b0;
        RegWr      = 1'b0;
        MemWr      = 1'b0;
        ALUctr     = ALU_ADDU;
        ALUSrc     = 1'b0;
        ExtOp      = 1'b0;
        RegDst     = 1'b0;
        MemtoReg   = 1'b0;
        nPCsel     = NPC_SEQ;
        instr_done = 1'b0;
        ill_op     = 1'b0;
        ovf_exc    = 1'b0;
        if (rst_n) begin
            case (state_q)
                S_IF: begin
                    PCWr = 1'b1;
                    IRWr = 1'b1;
                end
                S_ID:    ill_op = w_id_ill;
                S_EXE_R: ALUctr = w_fn_ctr;
                S_EXE_I: begin
                    ALUSrc = 1'b1;
                    if (op == OP_ORI) begin
                        ALUctr = ALU_OR;
                    end else begin
                        ExtOp  = 1'b1;
                    end
                end
                S_EXE_MA: begin
                    ALUSrc = 1'b1;
                    ExtOp  = 1'b1;
                end
                S_MEM_WR: begin
                    MemWr      = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_R: begin
                    RegDst     = 1'b1;
                    RegWr      = ~ov_flag_q;
                    ovf_exc    = ov_flag_q;
                    instr_done = 1'b1;
                end
                S_WB_I: begin
                    RegWr      = 1'b1;
                    instr_done = 1'b1;
                end
                S_WB_LD: begin
                    RegWr      = 1'b1;
                    MemtoReg   = 1'b1;
                    instr_done = 1'b1;
                end
                S_BR: begin
                    ALUctr     = ALU_SUBU;
                    ExtOp      = 1'b1;
                    nPCsel     = NPC_BR;
                    PCWr       = zero;
                    instr_done = 1'b1;
                end
                S_JMP: begin
                    nPCsel     = NPC_JMP;
                    PCWr       = 1'b1;
                    instr_done = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
